// File: rtl/sweep_pkg.sv
// sweep_pkg: shared definitions for the frequency-sweep controller.
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - averaging depth used when SWEEP_AVG_EN is defined
//   - helper that turns an accumulated sample sum into an average
package sweep_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SET    = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_MEAS   = 3'd3;
    localparam state_t ST_CMP    = 3'd4;
    localparam state_t ST_FIN    = 3'd5;

    // Number of magnitude samples averaged per step in averaging builds.
    localparam int AVG_DEPTH = 4;
    localparam int AVG_SHIFT = 2;
    localparam int AVG_CW    = 2;
    localparam int SUM_W     = 18;

    // Divide the accumulated sum by the averaging depth (power of two).
    function automatic logic [15:0] avg_of(input logic [SUM_W-1:0] sum);
        logic [SUM_W-1:0] shifted;
        shifted = sum >> AVG_SHIFT;
        return shifted[15:0];
    endfunction

endpackage

// File: rtl/sweep_if.sv
// sweep_if: bundle of the sweep controller's control, configuration,
// measurement and result signals.
//   slave  modport: controller side (sweep_ctrl)
//   master modport: requester / DDS / detector side
// Inputs to controller : start, abort, f_start, f_step, n_steps,
//                        settle_cyc, mag_in, mag_valid
// Outputs of controller: fre_out, refresh, busy, done, err,
//                        peak_fre, peak_mag, step_idx
interface sweep_if #(
    parameter int N_W      = 10,
    parameter int SETTLE_W = 16
);
    logic                start;
    logic                abort;
    logic [31:0]         f_start;
    logic [31:0]         f_step;
    logic [N_W-1:0]      n_steps;
    logic [SETTLE_W-1:0] settle_cyc;
    logic [15:0]         mag_in;
    logic                mag_valid;
    logic [31:0]         fre_out;
    logic                refresh;
    logic                busy;
    logic                done;
    logic                err;
    logic [31:0]         peak_fre;
    logic [15:0]         peak_mag;
    logic [N_W-1:0]      step_idx;

    modport slave (
        input  start, abort, f_start, f_step, n_steps, settle_cyc,
               mag_in, mag_valid,
        output fre_out, refresh, busy, done, err, peak_fre, peak_mag,
               step_idx
    );

    modport master (
        output start, abort, f_start, f_step, n_steps, settle_cyc,
               mag_in, mag_valid,
        input  fre_out, refresh, busy, done, err, peak_fre, peak_mag,
               step_idx
    );
endinterface

// File: rtl/sweep_timer.sv
// sweep_timer: loadable down-counter shared by the settle wait and the
// measurement timeout.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load count with load_val (priority over en)
//   load_val  : value to load
//   en        : decrement by one while non-zero
//   zero      : count is zero
module sweep_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] count_r;

    // Down-counter: reset, load, or decrement saturating at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});
endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: steps a DDS frequency word from f_start in f_step increments,
// waits settle_cyc after each update, takes a magnitude sample, and tracks
// the frequency giving the largest magnitude. On completion, abort or
// timeout it parks the DDS on the peak frequency and pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sweep_if.slave (start/abort, configuration, mag_in/mag_valid,
//              fre_out/refresh, busy/done/err, peak_fre/peak_mag, step_idx)
// Build option: define SWEEP_AVG_EN to average AVG_DEPTH samples per step.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int N_W      = 10,
    parameter int SETTLE_W = 16,
    parameter int TMO_CYC  = 65535
) (
    input  logic    clk,
    input  logic    rst,
    sweep_if.slave  bus
);
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int TW    = (SETTLE_W > TMO_W) ? SETTLE_W : TMO_W;
    // MEAS lasts TMO_CYC cycles: the timer counts TMO_CYC-1 down to zero.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYC - 1);
    localparam logic [N_W-1:0] ONE_N   = {{(N_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [31:0]         fre_out_r;
    logic                refresh_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [31:0]         peak_fre_r;
    logic [15:0]         peak_mag_r;
    logic [N_W-1:0]      step_idx_r;
    logic [31:0]         f_step_r;
    logic [N_W-1:0]      n_last_r;
    logic [SETTLE_W-1:0] settle_r;
    logic [15:0]         sample_r;

`ifdef SWEEP_AVG_EN
    logic [SUM_W-1:0]    avg_sum_r;
    logic [AVG_CW-1:0]   avg_cnt_r;
    logic [SUM_W-1:0]    avg_next_s;
`endif

    logic                tmr_load_s;
    logic [TW-1:0]       tmr_val_s;
    logic                tmr_en_s;
    logic                tmr_zero_s;

    sweep_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .en       (tmr_en_s),
        .zero     (tmr_zero_s)
    );

    // Timer control: settle load in SET, timeout load on MEAS entry and
    // after every accepted sample, count down while waiting.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = {TW{1'b0}};
        tmr_en_s   = 1'b0;
        case (state_r)
            ST_SET: begin
                tmr_load_s = 1'b1;
                tmr_val_s  = TW'(settle_r);
            end
            ST_SETTLE: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TMO_LOAD;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_MEAS: begin
                if (bus.mag_valid) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TMO_LOAD;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

`ifdef SWEEP_AVG_EN
    // Running sum including the sample presented this cycle.
    always_comb begin
        avg_next_s = avg_sum_r + {2'b00, bus.mag_in};
    end
`endif

    // Sweep FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fre_out_r  <= 32'd0;
            refresh_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            peak_fre_r <= 32'd0;
            peak_mag_r <= 16'd0;
            step_idx_r <= {N_W{1'b0}};
            f_step_r   <= 32'd0;
            n_last_r   <= {N_W{1'b0}};
            settle_r   <= {SETTLE_W{1'b0}};
            sample_r   <= 16'd0;
`ifdef SWEEP_AVG_EN
            avg_sum_r  <= {SUM_W{1'b0}};
            avg_cnt_r  <= {AVG_CW{1'b0}};
`endif
        end else begin
            refresh_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // start wins even if abort is high in the same cycle
                    if (bus.start) begin
                        f_step_r   <= bus.f_step;
                        n_last_r   <= (bus.n_steps == {N_W{1'b0}}) ?
                                      {N_W{1'b0}} : (bus.n_steps - ONE_N);
                        settle_r   <= bus.settle_cyc;
                        fre_out_r  <= bus.f_start;
                        step_idx_r <= {N_W{1'b0}};
                        peak_mag_r <= 16'd0;
                        peak_fre_r <= 32'd0;
                        err_r      <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SET;
                    end
                end
                ST_SET: begin
                    if (bus.abort) begin
                        state_r <= ST_FIN;
                    end else begin
                        refresh_r <= 1'b1;
`ifdef SWEEP_AVG_EN
                        avg_sum_r <= {SUM_W{1'b0}};
                        avg_cnt_r <= {AVG_CW{1'b0}};
`endif
                        state_r   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        state_r <= ST_FIN;
                    end else if (tmr_zero_s) begin
                        state_r <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (bus.abort) begin
                        state_r <= ST_FIN;
                    end else if (bus.mag_valid) begin
`ifdef SWEEP_AVG_EN
                        if (avg_cnt_r == AVG_CW'(AVG_DEPTH - 1)) begin
                            sample_r  <= avg_of(avg_next_s);
                            avg_sum_r <= {SUM_W{1'b0}};
                            avg_cnt_r <= {AVG_CW{1'b0}};
                            state_r   <= ST_CMP;
                        end else begin
                            avg_sum_r <= avg_next_s;
                            avg_cnt_r <= avg_cnt_r + {{(AVG_CW-1){1'b0}}, 1'b1};
                        end
`else
                        sample_r <= bus.mag_in;
                        state_r  <= ST_CMP;
`endif
                    end else if (tmr_zero_s) begin
                        err_r   <= 1'b1;
                        state_r <= ST_FIN;
                    end
                end
                ST_CMP: begin
                    if (bus.abort) begin
                        state_r <= ST_FIN;
                    end else begin
                        // strict compare: on a tie the earlier frequency stays
                        if (sample_r > peak_mag_r) begin
                            peak_mag_r <= sample_r;
                            peak_fre_r <= fre_out_r;
                        end
                        if (step_idx_r == n_last_r) begin
                            state_r <= ST_FIN;
                        end else begin
                            step_idx_r <= step_idx_r + ONE_N;
                            fre_out_r  <= fre_out_r + f_step_r;
                            state_r    <= ST_SET;
                        end
                    end
                end
                ST_FIN: begin
                    fre_out_r <= peak_fre_r;
                    refresh_r <= 1'b1;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fre_out  = fre_out_r;
    assign bus.refresh  = refresh_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
    assign bus.peak_fre = peak_fre_r;
    assign bus.peak_mag = peak_mag_r;
    assign bus.step_idx = step_idx_r;
endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter N_W, default 10: width of the step count and step index.
REQ-002 SHALL have parameter SETTLE_W, default 16: width of the settle counter.
REQ-003 SHALL have parameter TMO_CYC, default 65535: maximum cycles to wait for a magnitude sample.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1: one-cycle sweep request.
REQ-007 SHALL have port abort, input, 1: terminate the sweep.
REQ-008 SHALL have port f_start, input, 32: first DDS frequency word.
REQ-009 SHALL have port f_step, input, 32: frequency increment per step.
REQ-010 SHALL have port n_steps, input, N_W: number of steps; 0 means 1.
REQ-011 SHALL have port settle_cyc, input, SETTLE_W: wait after each frequency update.
REQ-012 SHALL have port mag_in, input, 16: unsigned phase-detector magnitude.
REQ-013 SHALL have port mag_valid, input, 1: mag_in qualifier.
REQ-014 SHALL have port fre_out, output, 32: frequency word driven to the DDS.
REQ-015 SHALL have port refresh, output, 1: one-cycle pulse on every fre_out change.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-018 SHALL have port err, output, 1: sticky timeout flag, cleared by the next start.
REQ-019 SHALL have port peak_fre, output, 32: fre_out at the maximum magnitude.
REQ-020 SHALL have port peak_mag, output, 16: the maximum magnitude.
REQ-021 SHALL have port step_idx, output, N_W: current step index.

Function
REQ-022 SHALL implement the states IDLE, SET, SETTLE, MEAS, CMP and FIN.
REQ-023 SHALL, in IDLE on start: latch all inputs, set fre_out=f_start, step_idx=0, peak_mag=0, err=0, and go to SET.
REQ-024 SHALL, in SET, pulse refresh for exactly one cycle, load the settle counter with settle_cyc, and go to SETTLE.
REQ-025 SHALL count SETTLE down to 0, then go to MEAS; settle_cyc=0 means SETTLE lasts exactly one cycle.
REQ-026 SHALL ignore mag_valid in every state except MEAS.
REQ-027 SHALL, in MEAS, capture mag_in on the first mag_valid and go to CMP.
REQ-028 SHALL, if TMO_CYC cycles pass in MEAS without mag_valid, set err and go to FIN.
REQ-029 SHALL, in CMP, replace peak_mag and peak_fre when the sample is strictly greater than peak_mag; ties keep the earlier frequency.
REQ-030 SHALL, in CMP, go to FIN when step_idx == max(n_steps,1)-1.
REQ-031 SHALL otherwise, in CMP, increment step_idx, set fre_out = fre_out + f_step (modulo 2^32, wrap-around permitted), and go to SET.
REQ-032 SHALL, in FIN, set fre_out=peak_fre, pulse refresh, pulse done, and go to IDLE in the same cycle.
REQ-033 SHALL, on a timeout, still load fre_out with peak_fre in FIN.
REQ-034 SHALL, on abort in any non-IDLE state, go to FIN at the next edge; abort takes priority over mag_valid and over a timeout in the same cycle.
REQ-035 SHALL ignore start while busy.
REQ-036 SHALL ignore abort in IDLE.
REQ-037 SHALL, with start and abort both high in IDLE, start the sweep.
REQ-038 SHALL have a latency from start to the first refresh of 2 cycles.

Reset
REQ-039 SHALL, on rst, force state=IDLE and fre_out=0, refresh=0, busy=0, done=0, err=0, peak_fre=0, peak_mag=0, step_idx=0 at the next edge.
REQ-040 SHALL take rst mid-sweep with priority over every other input, and SHALL NOT generate a done or refresh pulse.

Configuration
REQ-041 SHALL, with SWEEP_AVG_EN defined, make MEAS accumulate 4 valid samples into an 18-bit sum and pass sum>>2 to CMP, restarting the timeout per sample.
REQ-042 SHALL, without SWEEP_AVG_EN defined, use a single sample per step as described in REQ-027.

Structure
REQ-043 SHALL place the state enum and the averaging depth (4) in shared package sweep_pkg.
REQ-044 SHALL implement the settle/timeout down-counter as sub-module sweep_timer (load, enable, zero flag).

Verification
REQ-045 SHALL cover: f_start=1000, f_step=100, n_steps=4, settle_cyc=3, samples 5,9,9,2 -> refresh at fre 1000/1100/1200/1300, then 1100; peak_mag=9; one done pulse.
REQ-046 SHALL cover: n_steps=0 -> one measurement, done, peak_fre=f_start.
REQ-047 SHALL cover: f_start=0xFFFFFFF0, f_step=0x20, n_steps=2 -> second fre_out=0x00000010.
REQ-048 SHALL cover: no mag_valid for TMO_CYC cycles -> err=1, done pulse, fre_out=peak_fre (0 if no step measured).
REQ-049 SHALL cover: abort during SETTLE of step 2 -> FIN next cycle, done pulse, peak from step 1; start while busy ignored.
REQ-050 SHALL cover: rst asserted in MEAS -> all outputs 0 next edge, no done; with SWEEP_AVG_EN, samples 4,8,8,12 -> CMP value 8.
